// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU operation issuer.
//   Function-code constants (0..8) and the largest legal code FSEL_MAX.
//   Datapath widths: DATA_W (operand), SREG_W (ALU status), FSEL_W (function code).
//   state_t: issuer FSM states.
//   fsel_legal(): true when a function code names a real ALU operation.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SREG_W = 4;
  localparam int FSEL_W = 4;
  localparam int CNT_W  = 4;

  localparam logic [FSEL_W-1:0] FN_NOP   = 4'd0;
  localparam logic [FSEL_W-1:0] FN_ADD   = 4'd1;
  localparam logic [FSEL_W-1:0] FN_SUB   = 4'd2;
  localparam logic [FSEL_W-1:0] FN_MUL   = 4'd3;
  localparam logic [FSEL_W-1:0] FN_AND   = 4'd4;
  localparam logic [FSEL_W-1:0] FN_OR    = 4'd5;
  localparam logic [FSEL_W-1:0] FN_XOR   = 4'd6;
  localparam logic [FSEL_W-1:0] FN_SHL   = 4'd7;
  localparam logic [FSEL_W-1:0] FN_SHR   = 4'd8;
  localparam logic [FSEL_W-1:0] FSEL_MAX = FN_SHR;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  function automatic logic fsel_legal(input logic [FSEL_W-1:0] fsel);
    return (fsel <= FSEL_MAX);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo -- two-entry first-in first-out response buffer.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage and count)
//   push, din  : write din when push is high
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry (entry 0 always holds the oldest response)
//   count      : number of valid entries, 0..2
module alu_rsp_fifo #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         pop_ok;
  logic         push_ok;

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign dout    = ent0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves; the new entry lands behind whatever remains.
          if (count == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer -- issues one operation at a time to an external structural ALU,
// waits SETTLE_CYCLES clocks for it to settle, then queues the result.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        : command handshake; cmd_a, cmd_b, cmd_fsel carry it
//   alu_a, alu_b, alu_fsel     : registered operand/function drive to the ALU
//   alu_hi, alu_lo, alu_sreg   : ALU result halves and status
//   rsp_valid/rsp_ready        : response handshake from the 2-entry buffer
//   rsp_result, rsp_sreg       : {hi,lo} result and status of the head response
//   rsp_err                    : head response came from an illegal function code
//   busy                       : an operation is settling
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DATA_W        = alu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic [FSEL_W-1:0]   cmd_fsel,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [FSEL_W-1:0]   alu_fsel,
  input  logic [DATA_W-1:0]   alu_hi,
  input  logic [DATA_W-1:0]   alu_lo,
  input  logic [SREG_W-1:0]   alu_sreg,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [SREG_W-1:0]   rsp_sreg,
  output logic                rsp_err,
  output logic                busy
);

  localparam int RSP_W = 2*DATA_W + SREG_W + 1;
  // Counter counts down to zero; the push happens on the edge it is seen at zero.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               rdy_en;
  logic               accept;
  logic               legal;
  logic               push;
  logic               pop;
  logic [RSP_W-1:0]   push_data;
  logic [RSP_W-1:0]   fifo_dout;
  logic [1:0]         fifo_count;

  // rdy_en keeps cmd_ready low throughout reset and for the edge that releases it.
  assign cmd_ready = rdy_en && (state == IDLE) && (fifo_count < 2'd2);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = fsel_legal(cmd_fsel);
  assign busy      = (state == SETTLE);

  // Only one push source can be active: illegal accepts happen in IDLE,
  // settled results are captured in SETTLE.
  assign push = (accept && !legal) || ((state == SETTLE) && (cnt == '0));
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    push_data = {{(RSP_W-1){1'b0}}, 1'b1};
    if (state == SETTLE) push_data = {alu_hi, alu_lo, alu_sreg, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fsel <= '0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && legal) begin
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
            alu_fsel <= cmd_fsel;
            cnt      <= SETTLE_LOAD;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_rsp_fifo #(
    .W (RSP_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign rsp_valid = (fifo_count != 2'd0);
  assign {rsp_result, rsp_sreg, rsp_err} = fifo_dout;

endmodule
